// File: rtl/scalu_pkg.sv
// Shared opcode and exception encodings for the scalar ALU pipeline.
package scalu_pkg;

  localparam int OP_W     = 5;
  localparam int ECAUSE_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd2;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd7;
  localparam logic [OP_W-1:0] OP_OR    = 5'd8;
  localparam logic [OP_W-1:0] OP_AND   = 5'd9;
  localparam logic [OP_W-1:0] OP_PASS2 = 5'd10;

  localparam logic [ECAUSE_W-1:0] ECAUSE_NONE    = 5'd0;
  localparam logic [ECAUSE_W-1:0] ECAUSE_ILLEGAL = 5'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational scalar integer ALU; flags opcodes outside the defined set.
module alu_core
  import scalu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:   result = op1 + op2;
      OP_SUB:   result = op1 - op2;
      OP_SLL:   result = op1 << shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OP_XOR:   result = op1 ^ op2;
      OP_SRL:   result = op1 >> shamt;
      OP_SRA:   result = $unsigned($signed(op1) >>> shamt);
      OP_OR:    result = op1 | op2;
      OP_AND:   result = op1 & op2;
      OP_PASS2: result = op2;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/scalu_pipe.sv
// Scalar ALU with a STAGES-deep elastic output pipeline; invalid stages always
// accept, so issue stalls only when every slot ahead is full and writeback blocks.
module scalu_pipe
  import scalu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int STAGES  = 1,
  parameter int ROBID_W = 7,
  parameter int RD_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exers_scalu_issue,
  input  logic [OP_W-1:0]     exers_scalu_op,
  input  logic [ROBID_W-1:0]  exers_robid,
  input  logic [RD_W-1:0]     exers_rd,
  input  logic [XLEN-1:0]     exers_op1,
  input  logic [XLEN-1:0]     exers_op2,
  output logic                scalu_stall,
  output logic                scalu_valid,
  output logic                scalu_error,
  output logic [ECAUSE_W-1:0] scalu_ecause,
  output logic [ROBID_W-1:0]  scalu_robid,
  output logic [RD_W-1:0]     scalu_rd,
  output logic [XLEN-1:0]     scalu_result,
  input  logic                wb_scalu_stall,
  input  logic                rob_flush
);

  logic [XLEN-1:0]    alu_result;
  logic               alu_illegal;
  logic               accept;

  logic [STAGES-1:0]  valid_q, adv, nxt_valid, err_q, nxt_err;
  logic [XLEN-1:0]    res_q   [STAGES];
  logic [XLEN-1:0]    nxt_res [STAGES];
  logic [ROBID_W-1:0] robid_q   [STAGES];
  logic [ROBID_W-1:0] nxt_robid [STAGES];
  logic [RD_W-1:0]    rd_q   [STAGES];
  logic [RD_W-1:0]    nxt_rd [STAGES];

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .op      (exers_scalu_op),
    .op1     (exers_op1),
    .op2     (exers_op2),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Advance ripples backwards from writeback; an empty stage frees its predecessor.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~valid_q[STAGES-1] | ~wb_scalu_stall;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  assign scalu_stall = valid_q[0] & ~adv[0];
  assign accept      = exers_scalu_issue & ~scalu_stall;

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_head
      assign nxt_valid[g] = accept;
      assign nxt_err[g]   = alu_illegal;
      assign nxt_res[g]   = alu_result;
      assign nxt_robid[g] = exers_robid;
      assign nxt_rd[g]    = exers_rd;
    end else begin : g_body
      assign nxt_valid[g] = valid_q[g-1];
      assign nxt_err[g]   = err_q[g-1];
      assign nxt_res[g]   = res_q[g-1];
      assign nxt_robid[g] = robid_q[g-1];
      assign nxt_rd[g]    = rd_q[g-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
    if (rst || rob_flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) valid_q[i] <= nxt_valid[i];
      end
    end
  end

  // NOTE: payload is qualified by valid_q, so it carries no reset and needs no flush clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i]) begin
        err_q[i]   <= nxt_err[i];
        res_q[i]   <= nxt_res[i];
        robid_q[i] <= nxt_robid[i];
        rd_q[i]    <= nxt_rd[i];
      end
    end
  end

  assign scalu_valid  = valid_q[STAGES-1];
  assign scalu_error  = valid_q[STAGES-1] & err_q[STAGES-1];
  assign scalu_ecause = scalu_error ? ECAUSE_ILLEGAL : ECAUSE_NONE;
  assign scalu_robid  = robid_q[STAGES-1];
  assign scalu_rd     = rd_q[STAGES-1];
  assign scalu_result = res_q[STAGES-1];

endmodule
